xtl_clk_monitor: RTL and testbench
==================================

// Module: xtl_clk_monitor
// PURPOSE
//  Downstream consumer of the 20 MHz crystal-oscillator output (XTLOSC_CCC/O2F).
//  Samples that clock as data in the fabric clock domain, counts its rising edges per
//  fixed measurement window, and qualifies it before logic downstream relies on it.
//  Raises CLK_OK after consecutive in-band windows; flags a sticky fault on loss or
//  drift. Sits between the OSC wrapper and the CCC-lock and reset-release logic.
// PARAMETERS
//  WINDOW_CYCLES  1000  CLK cycles per measurement window (20 us at 50 MHz)
//  LO_COUNT       380   min XTL edges per window counted as good (inclusive)
//  HI_COUNT       420   max XTL edges per window counted as good (inclusive)
//  GOOD_WINDOWS   4     consecutive good windows needed to assert CLK_OK
//  CNT_W          12    width of edge counter / EDGE_COUNT (saturates at 2^CNT_W-1)
// PORTS
//  CLK          in   1      fabric clock, must be >2x XTL freq (50 MHz nominal)
//  RESET        in   1      synchronous, active-high
//  XTLOSC_IN    in   1      crystal clock, asynchronous to CLK, used as data only
//  ENABLE       in   1      1 = monitor runs; 0 = return to IDLE
//  FAIL_CLR     in   1      1-cycle pulse, clears FAIL_STICKY
//  CLK_OK       out  1      XTL qualified
//  FAIL_STICKY  out  1      set on any bad window while LOCKED; held until FAIL_CLR
//  EDGE_COUNT   out  CNT_W  edge count of last completed window
//  COUNT_VALID  out  1      1-cycle pulse when EDGE_COUNT updates
// BEHAVIOUR
//  - Reset: all outputs 0, all counters 0, sync flops 0, FSM = IDLE.
//  - Input path: 2-flop synchroniser s1,s2 plus s3; rise = s2 & ~s3. Pin-to-rise
//    latency 3 CLK cycles. Sync flops run regardless of ENABLE.
//  - Window counter wcnt 0..WINDOW_CYCLES-1, increments while state != IDLE.
//    Terminal cycle (wcnt = WINDOW_CYCLES-1) closes the window: rise in that cycle
//    is included; EDGE_COUNT <= final count next cycle with COUNT_VALID=1; edge
//    counter and wcnt restart at 0 (no edge lost or double-counted at wrap).
//  - Edge counter saturates at all-ones; a saturated window is out of band.
//  - good = (LO_COUNT <= count <= HI_COUNT), evaluated on the closed count.
//  - FSM states:
//    IDLE:    ENABLE=1 -> ACQUIRE (gcnt=0, counters cleared).
//    ACQUIRE: good window -> gcnt+1; bad -> gcnt=0; gcnt reaches GOOD_WINDOWS -> LOCKED.
//    LOCKED:  CLK_OK=1. Bad window -> FAULT, CLK_OK=0 and FAIL_STICKY=1 in the same
//             cycle COUNT_VALID pulses.
//    FAULT:   gcnt=0 on entry; re-qualifies exactly as ACQUIRE, then -> LOCKED.
//    Any state, ENABLE=0 -> IDLE next cycle; CLK_OK=0; wcnt, edge count, gcnt cleared;
//    EDGE_COUNT and FAIL_STICKY hold; partial window discarded, no COUNT_VALID.
//  - CLK_OK goes high the cycle after the qualifying COUNT_VALID pulse.
//  - FAIL_CLR and a new fault in the same cycle: set wins, FAIL_STICKY stays 1.
//  - RESET mid-window or while LOCKED: everything returns to reset values next edge.
// TESTING
//  1 XTL 20 MHz, CLK 50 MHz, ENABLE=1 -> EDGE_COUNT in 399..401 each window;
//    CLK_OK rises 1 cycle after 4th COUNT_VALID (~4000 cycles); FAIL_STICKY=0.
//  2 Locked, then XTL held low -> next window EDGE_COUNT=0, CLK_OK falls and
//    FAIL_STICKY rises with that COUNT_VALID; FAIL_CLR pulse -> FAIL_STICKY=0.
//  3 XTL 16 MHz -> EDGE_COUNT ~320 every window, CLK_OK never asserts, FAIL_STICKY=0.
//  4 Good,good,bad(0 edges),then 4 good windows -> CLK_OK only after the last 4
//    (gcnt reset on bad window in ACQUIRE).
//  5 ENABLE dropped mid-window of 2nd good window -> no COUNT_VALID, CLK_OK=0,
//    EDGE_COUNT holds; re-enable needs 4 fresh full windows.
//  6 CNT_W=4, WINDOW_CYCLES=100, XTL 20 MHz -> EDGE_COUNT=15 (saturated), bad window;
//    RESET asserted while LOCKED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/xtl_clk_monitor.sv
// rtl/xtl_clk_monitor.sv - windowed edge-count qualifier for the 20 MHz crystal clock
`timescale 1ns/1ps
module xtl_clk_monitor #(
   parameter int WINDOW_CYCLES = 1000,
   parameter int LO_COUNT      = 380,
   parameter int HI_COUNT      = 420,
   parameter int GOOD_WINDOWS  = 4,
   parameter int CNT_W         = 12
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             XTLOSC_IN,
   input  logic             ENABLE,
   input  logic             FAIL_CLR,
   output logic             CLK_OK,
   output logic             FAIL_STICKY,
   output logic [CNT_W-1:0] EDGE_COUNT,
   output logic             COUNT_VALID
);

   localparam int WCNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int GCNT_W = $clog2(GOOD_WINDOWS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      FAULT   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [GCNT_W-1:0] gcnt;
   logic [GCNT_W-1:0] gcnt_nx;
   logic              fault_set;

   logic              s1;
   logic              s2;
   logic              s3;
   logic              rise;

   logic [WCNT_W-1:0] wcnt;
   logic [CNT_W-1:0]  ecnt;
   logic [CNT_W-1:0]  closed;
   logic [31:0]       closed_ext;
   logic              win_done;
   logic              good;

   // Synchroniser plus edge-detect stage; runs regardless of ENABLE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= XTLOSC_IN;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Count including this cycle's edge; an all-ones count is treated as saturated
   assign closed     = (rise && (ecnt != '1)) ? ecnt + 1'b1 : ecnt;
   assign closed_ext = 32'(closed);
   assign win_done   = ENABLE && (state != IDLE) &&
                       (wcnt == WCNT_W'(WINDOW_CYCLES - 1));
   assign good       = (closed != '1) &&
                       (closed_ext >= 32'(LO_COUNT)) &&
                       (closed_ext <= 32'(HI_COUNT));

   // State and good-window counter registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         gcnt  <= '0;
      end else begin
         state <= state_nx;
         gcnt  <= gcnt_nx;
      end
   end

   // Qualification FSM: ENABLE low always wins and discards the partial window
   always_comb begin
      state_nx  = state;
      gcnt_nx   = gcnt;
      fault_set = 1'b0;
      if (!ENABLE) begin
         state_nx = IDLE;
         gcnt_nx  = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = ACQUIRE;
               gcnt_nx  = '0;
            end
            ACQUIRE, FAULT: begin
               if (gcnt == GCNT_W'(GOOD_WINDOWS)) begin
                  state_nx = LOCKED;
               end else if (win_done) begin
                  gcnt_nx = good ? gcnt + 1'b1 : '0;
               end
            end
            LOCKED: begin
               if (win_done && !good) begin
                  state_nx  = FAULT;
                  gcnt_nx   = '0;
                  fault_set = 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               gcnt_nx  = '0;
            end
         endcase
      end
   end

   // Window/edge counters, published count and sticky fault flag
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wcnt        <= '0;
         ecnt        <= '0;
         EDGE_COUNT  <= '0;
         COUNT_VALID <= 1'b0;
         FAIL_STICKY <= 1'b0;
      end else begin
         COUNT_VALID <= 1'b0;
         if (fault_set) begin
            FAIL_STICKY <= 1'b1;
         end else if (FAIL_CLR) begin
            FAIL_STICKY <= 1'b0;
         end
         if (!ENABLE || (state == IDLE)) begin
            wcnt <= '0;
            ecnt <= '0;
         end else if (win_done) begin
            wcnt        <= '0;
            ecnt        <= '0;
            EDGE_COUNT  <= closed;
            COUNT_VALID <= 1'b1;
         end else begin
            wcnt <= wcnt + 1'b1;
            ecnt <= closed;
         end
      end
   end

   assign CLK_OK = (state == LOCKED);

endmodule

// File: tb/tb_xtl_clk_monitor.sv
// tb/tb_xtl_clk_monitor.sv - directed self-checking bench for xtl_clk_monitor
`timescale 1ns/1ps
module tb_xtl_clk_monitor;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        en2;
   logic        fail_clr;
   logic        xtl;
   logic        xtl_raw;
   logic        xtl_run;
   realtime     xtl_half;

   logic        clk_ok;
   logic        fail_sticky;
   logic [11:0] edge_count;
   logic        count_valid;

   logic        clk_ok2;
   logic        fail_sticky2;
   logic [3:0]  edge_count2;
   logic        count_valid2;

   int checks = 0;
   int errors = 0;

   xtl_clk_monitor dut (
      .CLK         (clk),
      .RESET       (reset),
      .XTLOSC_IN   (xtl),
      .ENABLE      (enable),
      .FAIL_CLR    (fail_clr),
      .CLK_OK      (clk_ok),
      .FAIL_STICKY (fail_sticky),
      .EDGE_COUNT  (edge_count),
      .COUNT_VALID (count_valid)
   );

   xtl_clk_monitor #(
      .WINDOW_CYCLES (100),
      .LO_COUNT      (10),
      .HI_COUNT      (15),
      .GOOD_WINDOWS  (1),
      .CNT_W         (4)
   ) dut_small (
      .CLK         (clk),
      .RESET       (reset),
      .XTLOSC_IN   (xtl),
      .ENABLE      (en2),
      .FAIL_CLR    (fail_clr),
      .CLK_OK      (clk_ok2),
      .FAIL_STICKY (fail_sticky2),
      .EDGE_COUNT  (edge_count2),
      .COUNT_VALID (count_valid2)
   );

   // 50 MHz fabric clock, posedges at 10 + 20k ns
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Crystal clock, offset so its edges never coincide with a CLK posedge
   initial begin
      xtl_raw  = 1'b0;
      xtl_half = 25.0;
      #3;
      forever begin
         #(xtl_half) xtl_raw = ~xtl_raw;
      end
   end

   assign xtl = xtl_raw & xtl_run;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_cv(input int budget, output bit found, output bit ok_seen);
      found   = 1'b0;
      ok_seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (count_valid) begin
            found = 1'b1;
            break;
         end
         if (clk_ok) ok_seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; en2 = 1'b0; fail_clr = 1'b0; xtl_run = 1'b1;
      repeat (3) tick();
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset_clk_ok: got %b want 0", clk_ok); end
      checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL reset_fail_sticky: got %b want 0", fail_sticky); end
      checks++; if (edge_count !== 12'd0) begin errors++; $display("FAIL reset_edge_count: got %0d want 0", edge_count); end
      checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_count_valid: got %b want 0", count_valid); end
      checks++; if ({clk_ok2, fail_sticky2, edge_count2, count_valid2} !== 7'd0) begin
         errors++; $display("FAIL reset_small: got %b want 0", {clk_ok2, fail_sticky2, edge_count2, count_valid2});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_lock;
      bit f, ok;
      enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_cv(1100, f, ok);
         checks++; if (!f) begin errors++; $display("FAIL lock_cv_timeout: window %0d got none want pulse", k); end
         checks++; if (edge_count < 12'd399 || edge_count > 12'd401) begin
            errors++; $display("FAIL lock_edge_count: window %0d got %0d want 399..401", k, edge_count);
         end
         checks++; if (clk_ok !== 1'b0 || ok) begin errors++; $display("FAIL lock_early_ok: window %0d got %b want 0", k, clk_ok | ok); end
      end
      tick();
      checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL lock_clk_ok: got %b want 1", clk_ok); end
      checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL lock_fail_sticky: got %b want 0", fail_sticky); end
   endtask

   task automatic test_loss;
      bit f, ok;
      xtl_run = 1'b0;
      wait_cv(1100, f, ok);
      checks++; if (!f) begin errors++; $display("FAIL loss_cv_timeout: got none want pulse"); end
      checks++; if (edge_count >= 12'd380) begin errors++; $display("FAIL loss_count: got %0d want <380", edge_count); end
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL loss_clk_ok: got %b want 0", clk_ok); end
      checks++; if (fail_sticky !== 1'b1) begin errors++; $display("FAIL loss_fail_sticky: got %b want 1", fail_sticky); end
      wait_cv(1100, f, ok);
      checks++; if (!f || edge_count !== 12'd0) begin errors++; $display("FAIL loss_zero_count: got %0d (found %b) want 0", edge_count, f); end
      fail_clr = 1'b1;
      tick();
      fail_clr = 1'b0;
      checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL loss_clear: got %b want 0", fail_sticky); end
   endtask

   task automatic test_clr_collision;
      int ncv;
      bit locked;
      ncv = 0; locked = 1'b0;
      xtl_run = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (count_valid) ncv++;
         if (clk_ok) begin locked = 1'b1; break; end
      end
      checks++; if (!locked || ncv != 4) begin errors++; $display("FAIL relock: got locked=%b windows=%0d want 1/4", locked, ncv); end
      xtl_run = 1'b0;
      repeat (998) tick();
      fail_clr = 1'b1;
      tick();
      fail_clr = 1'b0;
      checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL collide_align: got %b want 1", count_valid); end
      checks++; if (fail_sticky !== 1'b1) begin errors++; $display("FAIL collide_set_wins: got %b want 1", fail_sticky); end
      checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL collide_clk_ok: got %b want 0", clk_ok); end
      fail_clr = 1'b1;
      tick();
      fail_clr = 1'b0;
      checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL collide_clear: got %b want 0", fail_sticky); end
   endtask

   task automatic test_freq_low;
      bit f, ok;
      xtl_half = 31.25;
      xtl_run  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_cv(1100, f, ok);
         checks++; if (!f || edge_count < 12'd315 || edge_count > 12'd322) begin
            errors++; $display("FAIL low_count: window %0d got %0d (found %b) want 315..322", k, edge_count, f);
         end
         checks++; if (clk_ok !== 1'b0 || ok) begin errors++; $display("FAIL low_clk_ok: window %0d got 1 want 0", k); end
         checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL low_fail_sticky: window %0d got %b want 0", k, fail_sticky); end
      end
   endtask

   task automatic test_requalify;
      bit f, ok;
      xtl_half = 25.0;
      enable = 1'b0;
      tick();
      enable = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) xtl_run = 1'b0;
         if (k == 3) xtl_run = 1'b1;
         wait_cv(1100, f, ok);
         checks++; if (!f) begin errors++; $display("FAIL requal_cv_timeout: window %0d got none want pulse", k); end
         if (k == 2) begin
            checks++; if (edge_count >= 12'd380) begin errors++; $display("FAIL requal_bad: got %0d want <380", edge_count); end
         end else begin
            checks++; if (edge_count < 12'd380 || edge_count > 12'd420) begin
               errors++; $display("FAIL requal_good: window %0d got %0d want 380..420", k, edge_count);
            end
         end
         checks++; if (clk_ok !== 1'b0 || ok) begin errors++; $display("FAIL requal_early_ok: window %0d got 1 want 0", k); end
      end
      tick();
      checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL requal_clk_ok: got %b want 1", clk_ok); end
      checks++; if (fail_sticky !== 1'b0) begin errors++; $display("FAIL requal_fail_sticky: got %b want 0", fail_sticky); end
   endtask

   task automatic test_enable_drop;
      bit f, ok, bad;
      int ncv, since;
      enable = 1'b0;
      tick();
      enable = 1'b1;
      wait_cv(1100, f, ok);
      checks++; if (!f || edge_count < 12'd399 || edge_count > 12'd401) begin
         errors++; $display("FAIL drop_first: got %0d (found %b) want 399..401", edge_count, f);
      end
      bad = 1'b0;
      repeat (500) begin tick(); if (count_valid || clk_ok) bad = 1'b1; end
      enable = 1'b0;
      repeat (1500) begin tick(); if (count_valid || clk_ok) bad = 1'b1; end
      checks++; if (bad) begin errors++; $display("FAIL drop_quiet: got activity want no pulse and clk_ok 0"); end
      checks++; if (edge_count < 12'd399 || edge_count > 12'd401) begin
         errors++; $display("FAIL drop_hold: got %0d want 399..401", edge_count);
      end
      enable = 1'b1;
      ncv = 0; since = 99; ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (count_valid) begin ncv++; since = 0; end else since++;
         if (clk_ok) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || ncv != 4 || since != 1) begin
         errors++; $display("FAIL drop_relock: got ok=%b windows=%0d lag=%0d want 1/4/1", ok, ncv, since);
      end
   endtask

   task automatic test_saturation_reset;
      int n2;
      bit seen;
      n2 = 0; seen = 1'b0;
      en2 = 1'b1;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (count_valid2) begin
            n2++;
            checks++; if (edge_count2 !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d want 15", edge_count2); end
         end
         if (clk_ok2) seen = 1'b1;
      end
      checks++; if (n2 != 2 || seen) begin errors++; $display("FAIL sat_windows: got %0d windows ok=%b want 2/0", n2, seen); end
      checks++; if (clk_ok !== 1'b1) begin errors++; $display("FAIL pre_reset_lock: got %b want 1", clk_ok); end
      reset = 1'b1;
      tick();
      checks++; if ({clk_ok, fail_sticky, edge_count, count_valid} !== 15'd0) begin
         errors++; $display("FAIL midrun_reset: got ok=%b fs=%b cnt=%0d cv=%b want all 0", clk_ok, fail_sticky, edge_count, count_valid);
      end
      checks++; if ({clk_ok2, fail_sticky2, edge_count2, count_valid2} !== 7'd0) begin
         errors++; $display("FAIL midrun_reset_small: got %b want 0", {clk_ok2, fail_sticky2, edge_count2, count_valid2});
      end
      reset = 1'b0;
      en2 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_lock();
      test_loss();
      test_clr_collision();
      test_freq_low();
      test_requalify();
      test_enable_drop();
      test_saturation_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
